// File: rtl/wb_pkg.sv
// Shared Wishbone widths, response/state enums and the byte-lane merge helper
// for the wb_reg_slave register responder.
package wb_pkg;

  localparam int WB_AW   = 30;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  // Kind of completion pulse a response register holds
  typedef enum logic [1:0] {
    NONE,
    ACK,
    ERR
  } wb_resp_e;

  // Wait-state sequencer states (IDLE -> WAIT -> RESP -> IDLE)
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } wb_wait_state_e;

  // Replace only the byte lanes whose select bit is set
  function automatic logic [WB_DW-1:0] wb_byte_merge(
    input logic [WB_DW-1:0]   old_val,
    input logic [WB_DW-1:0]   new_val,
    input logic [WB_SELW-1:0] sel
  );
    logic [WB_DW-1:0] res;
    res = old_val;
    for (int n = 0; n < WB_SELW; n++) begin
      if (sel[n]) res[8*n +: 8] = new_val[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_reg_slave_if.sv
// Wishbone B4 pipelined bus between the bus master and wb_reg_slave.
// Signal names are written from the responder's point of view (i_ = into
// the responder, o_ = out of it).
//
// Handshake: a request is taken on any rising edge where
// i_wb_cyc & i_wb_stb & !o_wb_stall. Every taken request is answered by
// exactly one single-cycle pulse of o_wb_ack or o_wb_err (never both), in
// request order. o_wb_data is meaningful only while o_wb_ack is high.
// Dropping i_wb_cyc abandons the cycle: outstanding responses are not driven.
interface wb_reg_slave_if;
  import wb_pkg::*;

  logic               i_wb_cyc;
  logic               i_wb_stb;
  logic               i_wb_we;
  logic [WB_AW-1:0]   i_wb_addr;
  logic [WB_DW-1:0]   i_wb_data;
  logic [WB_SELW-1:0] i_wb_sel;
  logic               o_wb_stall;
  logic               o_wb_ack;
  logic               o_wb_err;
  logic [WB_DW-1:0]   o_wb_data;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
  );

endinterface

// File: rtl/wb_regbank.sv
// Register array for wb_reg_slave: byte-merged writes, read mux and the
// RW / read-only ID / invalid address decode. o_valid says whether the
// presented access (read or write) targets a legal location.
module wb_regbank
  import wb_pkg::*;
#(
  parameter int               NREGS    = 8,
  parameter logic [WB_DW-1:0] ID_VALUE = 32'h5742_0001
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_wr_en,
  input  logic               i_is_write,
  input  logic [WB_AW-1:0]   i_addr,
  input  logic [WB_DW-1:0]   i_data,
  input  logic [WB_SELW-1:0] i_sel,
  output logic [WB_DW-1:0]   o_rdata,
  output logic               o_valid,
  output logic [7:0]         o_leds
);

  localparam logic [WB_AW-1:0] LP_ID_ADDR = WB_AW'(NREGS);

  logic [WB_DW-1:0] r_regs [NREGS];
  logic             w_is_rw;
  logic             w_is_id;

  assign w_is_rw = (i_addr < LP_ID_ADDR);
  assign w_is_id = (i_addr == LP_ID_ADDR);
  // The ID word is read-only, so a write there is as illegal as a bad address
  assign o_valid = w_is_rw | (w_is_id & ~i_is_write);
  assign o_leds  = r_regs[0][7:0];

  // Read mux: register contents or the ID constant; zero for writes/invalid
  always_comb begin
    o_rdata = '0;
    if (!i_is_write) begin
      if (w_is_id) o_rdata = ID_VALUE;
      for (int i = 0; i < NREGS; i++) begin
        if (i_addr == WB_AW'(i)) o_rdata = r_regs[i];
      end
    end
  end

  // Byte-lane write into the addressed RW register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_wr_en && w_is_rw) begin
      for (int i = 0; i < NREGS; i++) begin
        if (i_addr == WB_AW'(i)) r_regs[i] <= wb_byte_merge(r_regs[i], i_data, i_sel);
      end
    end
  end

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone B4 pipelined register responder. Owns the bus handshake, the
// optional wait-state sequencer and the registered ack/err/data response.
// Build option: define WB_SLAVE_WAIT_EN to insert WAIT_CYCLES stall cycles
// per access; otherwise a zero-wait, one-request-per-cycle responder is built.
module wb_reg_slave
  import wb_pkg::*;
#(
  parameter int               NREGS       = 8,
  parameter logic [WB_DW-1:0] ID_VALUE    = 32'h5742_0001,
  parameter int               WAIT_CYCLES = 2
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  wb_reg_slave_if.slave  wb,
  output logic [7:0]     o_leds,
  output wb_wait_state_e o_dbg_state
);

  logic               w_accept;
  logic               w_stall;
  logic               w_wr_en;
  logic               w_is_write;
  logic               w_load_resp;
  logic [WB_AW-1:0]   w_addr;
  logic [WB_DW-1:0]   w_wdata;
  logic [WB_SELW-1:0] w_sel;
  logic [WB_DW-1:0]   w_rdata;
  logic               w_valid;
  wb_resp_e           r_resp;
  logic [WB_DW-1:0]   r_data;

  assign w_accept      = wb.i_wb_cyc & wb.i_wb_stb & ~w_stall;
  assign wb.o_wb_stall = w_stall;
  // A dropped cyc masks the pulse on the very cycle it would be driven
  assign wb.o_wb_ack   = (r_resp == ACK) & wb.i_wb_cyc;
  assign wb.o_wb_err   = (r_resp == ERR) & wb.i_wb_cyc;
  assign wb.o_wb_data  = r_data;

`ifdef WB_SLAVE_WAIT_EN
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  wb_wait_state_e     r_state;
  wb_wait_state_e     w_state_next;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_next;
  logic               w_commit;
  logic               r_we;
  logic [WB_AW-1:0]   r_addr;
  logic [WB_DW-1:0]   r_wdata;
  logic [WB_SELW-1:0] r_sel;

  assign w_stall     = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;
  assign w_addr      = r_addr;
  assign w_wdata     = r_wdata;
  assign w_sel       = r_sel;
  assign w_is_write  = r_we;
  assign w_wr_en     = w_commit & r_we;
  // The response is captured on the same edge the write commits
  assign w_load_resp = w_commit;

  // Sequencer state and wait counter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state: count down the wait phase, abort if the master drops cyc
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_commit     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_WAIT;
          w_cnt_next   = LP_WAIT;
        end
      end
      ST_WAIT: begin
        if (!wb.i_wb_cyc) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_commit     = 1'b1;
            w_state_next = ST_RESP;
          end
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Hold the accepted request for the duration of the wait phase
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
    end else if (w_accept) begin
      r_we    <= wb.i_wb_we;
      r_addr  <= wb.i_wb_addr;
      r_wdata <= wb.i_wb_data;
      r_sel   <= wb.i_wb_sel;
    end
  end
`else
  logic [3:0] w_unused_wait_cycles;

  assign w_unused_wait_cycles = 4'(WAIT_CYCLES);
  assign w_stall     = 1'b0;
  assign o_dbg_state = ST_IDLE;
  assign w_addr      = wb.i_wb_addr;
  assign w_wdata     = wb.i_wb_data;
  assign w_sel       = wb.i_wb_sel;
  assign w_is_write  = wb.i_wb_we;
  assign w_wr_en     = w_accept & wb.i_wb_we;
  assign w_load_resp = w_accept;
`endif

  // Register one response per accepted (or committed) request
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_resp <= NONE;
      r_data <= '0;
    end else if (w_load_resp) begin
      r_resp <= w_valid ? ACK : ERR;
      r_data <= (w_valid && !w_is_write) ? w_rdata : '0;
    end else begin
      r_resp <= NONE;
      r_data <= '0;
    end
  end

  wb_regbank #(
    .NREGS    (NREGS),
    .ID_VALUE (ID_VALUE)
  ) u_regbank (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_wr_en    (w_wr_en),
    .i_is_write (w_is_write),
    .i_addr     (w_addr),
    .i_data     (w_wdata),
    .i_sel      (w_sel),
    .o_rdata    (w_rdata),
    .o_valid    (w_valid),
    .o_leds     (o_leds)
  );

endmodule

// File: tb/tb_wb_reg_slave.sv
// Directed bench for wb_reg_slave: driver tasks push the expected response
// into exp_q when a request is issued; a monitor pops and compares on every
// ack/err pulse.
module tb_wb_reg_slave;
  import wb_pkg::*;

`ifdef WB_SLAVE_WAIT_EN
  localparam int LAT    = 3;
  localparam int PERIOD = 4;
`else
  localparam int LAT    = 1;
  localparam int PERIOD = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     leds;
  wb_wait_state_e dbg_state;

  wb_reg_slave_if bus ();

  wb_reg_slave #(
    .NREGS       (8),
    .ID_VALUE    (32'h5742_0001),
    .WAIT_CYCLES (2)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .wb          (bus),
    .o_leds      (leds),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q[$];
  int          acc_stamps[$];
  int          resp_stamps[$];

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] e_ack(input logic [31:0] d);
    return {2'b10, d};
  endfunction

  function automatic logic [33:0] e_err();
    return {2'b01, 32'h0};
  endfunction

  // Monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && (bus.o_wb_ack || bus.o_wb_err)) begin
      resp_stamps.push_back(cyc_n);
      chk("ack_err_exclusive", 34'(bus.o_wb_ack & bus.o_wb_err), 34'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got ack=%0b err=%0b data=%h want no response",
                 bus.o_wb_ack, bus.o_wb_err, bus.o_wb_data);
      end else begin
        chk("resp", {bus.o_wb_ack, bus.o_wb_err, bus.o_wb_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
  endtask

  // Present one request, hold it until taken, optionally expect a response
  task automatic issue(input logic we, input logic [29:0] addr, input logic [31:0] data,
                       input logic [3:0] sel, input logic push, input logic [33:0] exp);
    logic st;
    int   n;
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = we;
    bus.i_wb_addr = addr;
    bus.i_wb_data = data;
    bus.i_wb_sel  = sel;
    if (push) exp_q.push_back(exp);
    n = 0;
    do begin
      st = bus.o_wb_stall;
`ifndef WB_SLAVE_WAIT_EN
      chk("stall_zero", 34'(st), 34'd0);
`endif
      @(posedge clk);
      #1;
      n++;
    end while (st && n < 50);
    if (st) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got stall=1 after %0d cycles want accepted", n);
    end
    acc_stamps.push_back(cyc_n);
    bus.i_wb_stb = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_outstanding", 34'(exp_q.size()), 34'd0);
    exp_q.delete();
    idle();
    cycles(2);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] burst_v [4];
  int          n_before;
  int          wn;

  initial begin
    burst_v[0] = 32'h0000_00A5;
    burst_v[1] = 32'h0000_0005;
    burst_v[2] = 32'hFF22_FF44;
    burst_v[3] = 32'h0000_0000;
    idle();
    bus.i_wb_addr = '0;
    bus.i_wb_data = '0;
    bus.i_wb_sel  = '0;
    rst_n = 1'b0;
    cycles(3);
    chk("rst_ack",   34'(bus.o_wb_ack),   34'd0);
    chk("rst_err",   34'(bus.o_wb_err),   34'd0);
    chk("rst_data",  34'(bus.o_wb_data),  34'd0);
    chk("rst_stall", 34'(bus.o_wb_stall), 34'd0);
    chk("rst_leds",  34'(leds),           34'd0);
    rst_n = 1'b1;
    cycles(1);

    // write then immediately read back
    issue(1'b1, 30'd1, 32'd5, 4'hF, 1'b1, e_ack(32'h0));
    issue(1'b0, 30'd1, 32'd0, 4'hF, 1'b1, e_ack(32'h0000_0005));
    drain();

    // register 0 drives the LEDs from the edge of the write's ack
    issue(1'b1, 30'd0, 32'h0000_00A5, 4'hF, 1'b1, e_ack(32'h0));
    wn = 0;
    while (!bus.o_wb_ack && wn < 20) begin
      @(posedge clk);
      #1;
      wn++;
    end
    chk("leds_on_ack", 34'(leds), 34'h0A5);
    drain();

    // byte-lane writes
    issue(1'b1, 30'd2, 32'hFFFF_FFFF, 4'hF,    1'b1, e_ack(32'h0));
    issue(1'b1, 30'd2, 32'h1122_3344, 4'b0101, 1'b1, e_ack(32'h0));
    issue(1'b0, 30'd2, 32'h0,         4'h0,    1'b1, e_ack(32'hFF22_FF44));
    issue(1'b1, 30'd2, 32'hDEAD_BEEF, 4'h0,    1'b1, e_ack(32'h0));
    issue(1'b0, 30'd2, 32'h0,         4'hF,    1'b1, e_ack(32'hFF22_FF44));
    drain();

    // ID word and invalid addresses
    issue(1'b0, 30'd8,          32'h0,         4'hF, 1'b1, e_ack(32'h5742_0001));
    issue(1'b0, 30'd9,          32'h0,         4'hF, 1'b1, e_err());
    issue(1'b1, 30'd8,          32'h1234_5678, 4'hF, 1'b1, e_err());
    issue(1'b0, 30'd8,          32'h0,         4'hF, 1'b1, e_ack(32'h5742_0001));
    issue(1'b1, 30'h3FFF_FFFF,  32'hFFFF_FFFF, 4'hF, 1'b1, e_err());
    issue(1'b0, 30'd1,          32'h0,         4'hF, 1'b1, e_ack(32'h0000_0005));
    drain();

    // back-to-back reads: latency and spacing of the responses
    acc_stamps.delete();
    resp_stamps.delete();
    for (int i = 0; i < 4; i++) issue(1'b0, 30'(i), 32'h0, 4'h0, 1'b1, e_ack(burst_v[i]));
    drain();
    chk("burst_count", 34'(resp_stamps.size()), 34'd4);
    if (resp_stamps.size() == 4 && acc_stamps.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("burst_latency", 34'(resp_stamps[i] - acc_stamps[i] + 1), 34'(LAT));
        if (i > 0) chk("burst_spacing", 34'(resp_stamps[i] - resp_stamps[i-1]), 34'(PERIOD));
      end
    end

    // master drops cyc right after a write is taken: no pulse may appear
    n_before = resp_stamps.size();
    issue(1'b1, 30'd3, 32'h1234_5678, 4'hF, 1'b0, 34'h0);
    idle();
    cycles(6);
    chk("suppress_no_resp", 34'(resp_stamps.size() - n_before), 34'd0);
`ifdef WB_SLAVE_WAIT_EN
    issue(1'b0, 30'd3, 32'h0, 4'hF, 1'b1, e_ack(32'h0));
`else
    issue(1'b0, 30'd3, 32'h0, 4'hF, 1'b1, e_ack(32'h1234_5678));
`endif
    drain();

    // reset in the middle of an access
    issue(1'b0, 30'd0, 32'h0, 4'hF, 1'b0, 34'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack",   34'(bus.o_wb_ack),   34'd0);
    chk("midrst_err",   34'(bus.o_wb_err),   34'd0);
    chk("midrst_data",  34'(bus.o_wb_data),  34'd0);
    chk("midrst_stall", 34'(bus.o_wb_stall), 34'd0);
    chk("midrst_leds",  34'(leds),           34'd0);
    idle();
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    issue(1'b0, 30'd0, 32'h0, 4'hF, 1'b1, e_ack(32'h0));
    issue(1'b0, 30'd2, 32'h0, 4'hF, 1'b1, e_ack(32'h0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no end of test want completion before 200000");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
